// File: rtl/vram_arb_pkg.sv
// Shared types and helpers for the playfield/brick RAM scan arbiter.
// Slot phases are decoded from the low bits of the horizontal count.
package vram_arb_pkg;

  localparam int unsigned TILE_ADDR_W = 10;
  localparam int unsigned TILE_IDX_W  = 5;

  localparam logic [2:0] FETCH_PHASE = 3'd6;
  localparam logic [2:0] GUARD_PHASE = 3'd5;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    VID_A = 3'd1,
    VID_D = 3'd2,
    CPU_A = 3'd3,
    CPU_D = 3'd4
  } arb_state_e;

  // Tile address: row from the coarse vertical count, column from the coarse horizontal count
  function automatic logic [TILE_ADDR_W-1:0] tile_addr(input logic [TILE_IDX_W-1:0] vrow,
                                                       input logic [TILE_IDX_W-1:0] hcol);
    return {vrow, hcol};
  endfunction

endpackage

// File: rtl/flip_sync.sv
// Cocktail-flip sequencer: the applied flip level only follows the request
// at the rising edge of vertical sync, so the picture never flips mid-frame.
module flip_sync (
  input  logic clk_drv,
  input  logic reset_n,
  input  logic vsync,
  input  logic flip_req,
  output logic flip
);

  logic vsync_q;
  logic vsync_rise;

  assign vsync_rise = vsync & ~vsync_q;

  always_ff @(posedge clk_drv or negedge reset_n) begin
    if (!reset_n) begin
      vsync_q <= 1'b0;
      flip    <= 1'b0;
    end else begin
      vsync_q <= vsync;
      if (vsync_rise) begin
        flip <= flip_req;
      end
    end
  end

endmodule

// File: rtl/vram_scan_arbiter.sv
// Single-port playfield RAM arbiter: video scan owns fixed fetch slots, the
// CPU side gets the remaining slots and blanking; also sequences cocktail flip.
module vram_scan_arbiter
  import vram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned WAIT_MAX = 255
) (
  input  logic              clk_drv,
  input  logic              reset_n,
  input  logic              ce_pix,
  input  logic [7:0]        hcnt,
  input  logic [7:0]        vcnt,
  input  logic              active,
  input  logic              vsync,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              flip_req,
  output logic              flip,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] vid_data,
  output logic              vid_stb,
  output logic              starve
);

  localparam int unsigned WAIT_W = $clog2(WAIT_MAX + 1);

  arb_state_e state;
  arb_state_e state_nxt;

  logic [2:0]        phase;
  logic              win;
  logic              fetch_trig;
  logic              cpu_grant;
  logic              cpu_busy;
  logic              cpu_waiting;
  logic              acc_we;
  logic              acc_we_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_cnt_nxt;

  logic [ADDR_W-1:0] ram_addr_nxt;
  logic              ram_we_nxt;
  logic [DATA_W-1:0] ram_wdata_nxt;
  logic [DATA_W-1:0] vid_data_nxt;
  logic              vid_stb_nxt;
  logic              cpu_ack_nxt;
  logic [DATA_W-1:0] cpu_rdata_nxt;

  logic              unused_vcnt_fine;

  assign unused_vcnt_fine = ^vcnt[2:0];

  // Slot decode: phases 5..7 of each 8-pixel cell belong to video while visible
  assign phase      = hcnt[2:0];
  assign win        = active && (phase >= GUARD_PHASE);
  assign fetch_trig = ce_pix && active && (phase == FETCH_PHASE);

  // No grant in the ACK cycle: the requester still holds CPU_REQ there
  assign cpu_grant  = (state == IDLE) && cpu_req && !win && !fetch_trig && !cpu_ack;
  assign cpu_busy   = (state == CPU_A) || (state == CPU_D);
  assign cpu_waiting = cpu_req && !cpu_grant && !cpu_busy;

  always_ff @(posedge clk_drv or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (fetch_trig) begin
          state_nxt = VID_A;
        end else if (cpu_grant) begin
          state_nxt = CPU_A;
        end
      end
      VID_A:   state_nxt = VID_D;
      VID_D:   state_nxt = IDLE;
      CPU_A:   state_nxt = CPU_D;
      CPU_D:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the registered RAM, video and CPU-side outputs
  always_comb begin
    ram_addr_nxt  = ram_addr;
    ram_we_nxt    = 1'b0;
    ram_wdata_nxt = '0;
    vid_data_nxt  = vid_data;
    vid_stb_nxt   = 1'b0;
    cpu_ack_nxt   = 1'b0;
    cpu_rdata_nxt = cpu_rdata;
    acc_we_nxt    = acc_we;
    case (state)
      IDLE: begin
        if (fetch_trig) begin
          ram_addr_nxt = ADDR_W'(tile_addr(vcnt[7:3], hcnt[7:3]));
        end else if (cpu_grant) begin
          ram_addr_nxt = cpu_addr;
          ram_we_nxt   = cpu_we;
          acc_we_nxt   = cpu_we;
          if (cpu_we) begin
            ram_wdata_nxt = cpu_wdata;
          end
        end
      end
      VID_D: begin
        vid_data_nxt = ram_rdata;
        vid_stb_nxt  = 1'b1;
      end
      CPU_D: begin
        cpu_ack_nxt = 1'b1;
        if (!acc_we) begin
          cpu_rdata_nxt = ram_rdata;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_drv or negedge reset_n) begin
    if (!reset_n) begin
      ram_addr  <= '0;
      ram_we    <= 1'b0;
      ram_wdata <= '0;
      vid_data  <= '0;
      vid_stb   <= 1'b0;
      cpu_ack   <= 1'b0;
      cpu_rdata <= '0;
      acc_we    <= 1'b0;
    end else begin
      ram_addr  <= ram_addr_nxt;
      ram_we    <= ram_we_nxt;
      ram_wdata <= ram_wdata_nxt;
      vid_data  <= vid_data_nxt;
      vid_stb   <= vid_stb_nxt;
      cpu_ack   <= cpu_ack_nxt;
      cpu_rdata <= cpu_rdata_nxt;
      acc_we    <= acc_we_nxt;
    end
  end

  // Starvation monitor: saturating wait count, sticky flag once it tops out
  always_comb begin
    wait_cnt_nxt = wait_cnt;
    if (cpu_grant) begin
      wait_cnt_nxt = '0;
    end else if (cpu_waiting && (wait_cnt != WAIT_W'(WAIT_MAX))) begin
      wait_cnt_nxt = wait_cnt + WAIT_W'(1);
    end
  end

  always_ff @(posedge clk_drv or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= '0;
      starve   <= 1'b0;
    end else begin
      wait_cnt <= wait_cnt_nxt;
      if (wait_cnt_nxt == WAIT_W'(WAIT_MAX)) begin
        starve <= 1'b1;
      end
    end
  end

  flip_sync u_flip_sync (
    .clk_drv  (clk_drv),
    .reset_n  (reset_n),
    .vsync    (vsync),
    .flip_req (flip_req),
    .flip     (flip)
  );

endmodule

// File: tb/tb_vram_scan_arbiter.sv
// Scoreboard bench for vram_scan_arbiter: video and CPU expectations are queued
// when stimulus is driven and retired when VID_STB / CPU_ACK appear.
module tb_vram_scan_arbiter;

  localparam int unsigned ADDR_W   = 10;
  localparam int unsigned DATA_W   = 8;
  localparam int unsigned WAIT_MAX = 8;
  localparam int unsigned DEPTH    = 1 << ADDR_W;

  logic              clk_drv   = 1'b0;
  logic              reset_n   = 1'b0;
  logic              ce_pix    = 1'b0;
  logic [7:0]        hcnt      = 8'h00;
  logic [7:0]        vcnt      = 8'h00;
  logic              active    = 1'b0;
  logic              vsync     = 1'b0;
  logic              cpu_req   = 1'b0;
  logic              cpu_we    = 1'b0;
  logic [ADDR_W-1:0] cpu_addr  = '0;
  logic [DATA_W-1:0] cpu_wdata = '0;
  logic              flip_req  = 1'b0;
  logic [DATA_W-1:0] ram_rdata = '0;

  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;
  logic              flip;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] vid_data;
  logic              vid_stb;
  logic              starve;

  logic [DATA_W-1:0] mem    [0:DEPTH-1];
  logic [DATA_W-1:0] shadow [0:DEPTH-1];
  logic              mem_loaded = 1'b0;

  typedef struct {
    logic              rd;
    logic [DATA_W-1:0] data;
    int                cyc;
  } exp_t;

  exp_t vid_q[$];
  exp_t cpu_q[$];

  int cyc     = 0;
  int n_chk   = 0;
  int n_pass  = 0;
  int we_cnt  = 0;
  int stb_cnt = 0;

  vram_scan_arbiter #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .WAIT_MAX (WAIT_MAX)
  ) dut (
    .clk_drv   (clk_drv),
    .reset_n   (reset_n),
    .ce_pix    (ce_pix),
    .hcnt      (hcnt),
    .vcnt      (vcnt),
    .active    (active),
    .vsync     (vsync),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_ack   (cpu_ack),
    .cpu_rdata (cpu_rdata),
    .flip_req  (flip_req),
    .flip      (flip),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .vid_data  (vid_data),
    .vid_stb   (vid_stb),
    .starve    (starve)
  );

  always #5 clk_drv = ~clk_drv;

  // Synchronous single-port RAM, preloaded with addr[7:0] on the first clock
  always @(posedge clk_drv) begin
    if (!mem_loaded) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= DATA_W'(i);
      mem_loaded <= 1'b1;
    end else if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
    ram_rdata <= mem[ram_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, cyc);
  endtask

  // Advance one clock, then retire any output events against the scoreboard
  task automatic tick();
    exp_t e;
    @(posedge clk_drv);
    #1;
    cyc++;
    if (ram_we) we_cnt++;
    if (vid_stb) begin
      stb_cnt++;
      if (vid_q.size() == 0) begin
        check("vid_stb_expected", 32'(vid_q.size()), 32'd1);
      end else begin
        e = vid_q.pop_front();
        check("vid_data", 32'(vid_data), 32'(e.data));
        check("vid_latency", 32'(cyc), 32'(e.cyc));
      end
    end
    if (cpu_ack) begin
      cpu_req = 1'b0;
      if (cpu_q.size() == 0) begin
        check("cpu_ack_expected", 32'(cpu_q.size()), 32'd1);
      end else begin
        e = cpu_q.pop_front();
        check("cpu_ack_latency", 32'(cyc), 32'(e.cyc));
        if (e.rd) check("cpu_rdata", 32'(cpu_rdata), 32'(e.data));
      end
    end
  endtask

  task automatic step_pix(input logic [7:0] h);
    logic [ADDR_W-1:0] ta;
    hcnt   = h;
    ce_pix = 1'b1;
    ta     = {vcnt[7:3], h[7:3]};
    if (active && (h[2:0] == 3'd6)) vid_q.push_back('{rd: 1'b0, data: shadow[ta], cyc: cyc + 3});
    tick();
    ce_pix = 1'b0;
    tick();
    tick();
    tick();
  endtask

  task automatic cpu_start(input logic we, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d, input int ack_off);
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = a;
    cpu_wdata = d;
    cpu_q.push_back('{rd: !we, data: (we ? d : shadow[a]), cyc: cyc + ack_off});
    if (we) shadow[a] = d;
  endtask

  task automatic wait_ack();
    int n = 0;
    while (cpu_req && n < 64) begin
      tick();
      n++;
    end
    if (cpu_req) begin
      check("cpu_ack_timeout", 32'(cpu_req), 32'd0);
      cpu_req = 1'b0;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cpu_ack"},   32'(cpu_ack),   32'd0);
    check({tag, "_cpu_rdata"}, 32'(cpu_rdata), 32'd0);
    check({tag, "_flip"},      32'(flip),      32'd0);
    check({tag, "_ram_addr"},  32'(ram_addr),  32'd0);
    check({tag, "_ram_we"},    32'(ram_we),    32'd0);
    check({tag, "_ram_wdata"}, 32'(ram_wdata), 32'd0);
    check({tag, "_vid_data"},  32'(vid_data),  32'd0);
    check({tag, "_vid_stb"},   32'(vid_stb),   32'd0);
    check({tag, "_starve"},    32'(starve),    32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < int'(DEPTH); i++) shadow[i] = DATA_W'(i);

    // Reset state
    reset_n = 1'b0;
    tick(); tick(); tick();
    check_all_zero("reset");
    reset_n = 1'b1;
    tick(); tick();

    // Idle scan of one visible line
    active  = 1'b1;
    vcnt    = 8'h28;
    stb_cnt = 0;
    for (int h = 0; h < 256; h++) begin
      step_pix(8'(h));
      if (h == 8'h1E) check("vid_tile_5_3", 32'(vid_data), 32'hA3);
    end
    check("stb_per_line", 32'(stb_cnt), 32'd32);

    // CPU write then read in blanking; the read is held through the ACK cycle
    active = 1'b0;
    we_cnt = 0;
    cpu_start(1'b1, 10'h123, 8'hA5, 3);
    wait_ack();
    cpu_start(1'b0, 10'h123, 8'h00, 4);
    wait_ack();
    tick(); tick();
    check("write_we_cycles", 32'(we_cnt), 32'd1);
    check("cpu_rdata_held", 32'(cpu_rdata), 32'hA5);
    check("ram_addr_held", 32'(ram_addr), 32'h123);

    // Collision: request in the same cycle as the fetch trigger
    active = 1'b1;
    vcnt   = 8'h10;
    we_cnt = 0;
    for (int h = 8'h40; h < 8'h46; h++) step_pix(8'(h));
    cpu_start(1'b0, 10'h123, 8'h00, 11);
    for (int h = 8'h46; h < 8'h50; h++) step_pix(8'(h));
    check("collision_no_we", 32'(we_cnt), 32'd0);

    // Guard slot: request raised at phase 5 waits for phase 0
    for (int h = 8'h50; h < 8'h55; h++) step_pix(8'(h));
    cpu_start(1'b0, 10'h010, 8'h00, 15);
    for (int h = 8'h55; h < 8'h5A; h++) step_pix(8'(h));
    wait_ack();

    // Flip only follows the request at a VSYNC rise
    active   = 1'b0;
    flip_req = 1'b1;
    tick(); tick(); tick(); tick(); tick();
    check("flip_hold_midframe", 32'(flip), 32'd0);
    vsync = 1'b1;
    tick();
    check("flip_on_vsync", 32'(flip), 32'd1);
    tick(); tick();
    flip_req = 1'b0;
    tick(); tick(); tick();
    check("flip_no_rise", 32'(flip), 32'd1);
    vsync = 1'b0;
    tick(); tick();
    vsync = 1'b1;
    tick();
    check("flip_off_vsync", 32'(flip), 32'd0);
    vsync = 1'b0;
    tick();
    flip_req = 1'b1;
    tick(); tick(); tick();
    flip_req = 1'b0;
    tick(); tick();
    vsync = 1'b1;
    tick();
    check("flip_pulse_ignored", 32'(flip), 32'd0);
    vsync = 1'b0;
    tick();

    // Starvation with grants blocked by the guard slot
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    active    = 1'b1;
    hcnt      = 8'h5D;
    cpu_req   = 1'b1;
    cpu_we    = 1'b1;
    cpu_addr  = 10'h3FF;
    cpu_wdata = 8'h5A;
    for (int i = 0; i < 7; i++) tick();
    check("starve_before_max", 32'(starve), 32'd0);
    tick();
    check("starve_at_max", 32'(starve), 32'd1);

    // Reset in the middle of a granted write abandons it silently
    active = 1'b0;
    tick();
    check("cpu_a_ram_we", 32'(ram_we), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("midreset");
    cpu_req = 1'b0;
    tick(); tick(); tick();
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    check("aborted_write", 32'(mem[10'h3FF]), 32'hFF);

    check("vid_q_drained", 32'(vid_q.size()), 32'd0);
    check("cpu_q_drained", 32'(cpu_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
